rc5_decrypt: RTL

RC5-W/R/b block decryption core. It is the inverse-direction counterpart of the key-expansion/encryption path.
- Takes one 2W-bit ciphertext block (A,B) and reads the expanded key table S from an external synchronous-read RAM, one word at a time, from S[2R+1] down to S[0].
- Runs R decryption rounds and returns the plaintext with a done pulse.
- Sits beside the S RAM as that RAM's second reader, after key expansion has completed.

---
 rtl/rc5_decrypt.sv | 89 ++++++++
 1 files changed

// File: rtl/rc5_decrypt.sv
// rc5_decrypt: RC5-W/R decryption core that streams the expanded key S from an external synchronous-read RAM
module rc5_decrypt #(
  parameter int W        = 32,
  parameter int W_bits   = $clog2(W),
  parameter int R        = 12,
  parameter int T        = 2*(R+1),
  parameter int T_length = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        ct_a,
  input  logic [W-1:0]        ct_b,
  output logic [T_length-1:0] S_address,
  input  logic [W-1:0]        S_sub_i,
  output logic [W-1:0]        pt_a,
  output logic [W-1:0]        pt_b,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [T_length-1:0] K_TOP = T_length'(T-1);
  state_t              r_state, w_next;
  logic [T_length-1:0] r_k;
  logic [W-1:0]        r_a, r_b, w_sub, w_x, w_round;
  logic [W_bits-1:0]   w_amt;
  logic [2*W-1:0]      w_rot;
  logic                w_go;
  // the done cycle is spent in IDLE but must not accept a new block
  assign w_go = start && !done;
  // half-round: odd k updates B, even k updates A; the other word gives rotate amount and xor mask
  always_comb begin
    w_sub   = (r_k[0] ? r_b : r_a) - S_sub_i;
    w_x     = r_k[0] ? r_a : r_b;
    w_amt   = w_x[W_bits-1:0];
    w_rot   = {w_sub, w_sub} >> w_amt;
    w_round = w_rot[W-1:0] ^ w_x;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  // next state: ADDR/DATA alternate once per key word, DATA at k==0 finishes
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? ADDR : IDLE;
      ADDR:    w_next = DATA;
      DATA:    w_next = (r_k == '0) ? IDLE : ADDR;
      default: w_next = IDLE;
    endcase
  end
  // datapath, RAM address and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      S_address <= '0;
      pt_a      <= '0;
      pt_b      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE && w_go) begin
        r_a       <= ct_a;
        r_b       <= ct_b;
        r_k       <= K_TOP;
        S_address <= K_TOP;
        busy      <= 1'b1;
      end else if (r_state == DATA) begin
        if (r_k == '0) begin
          pt_a <= w_sub;
          pt_b <= r_b;
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          r_k       <= r_k - 1'b1;
          S_address <= r_k - 1'b1;
          if (r_k == T_length'(1)) r_b <= w_sub;
          else if (r_k[0])         r_b <= w_round;
          else                     r_a <= w_round;
        end
      end
    end
  end
endmodule
